// File: rtl/transpose_pp.sv
// transpose_pp: ping-pong transpose memory sitting between the row and
// column DCT passes. Rows are written into one bank while the other bank
// is read out column by column, so each side can move one beat per cycle.
//
// Optional build macro: TRANSPOSE_PP_PASSTHRU_EN
//   Adds a passthru input. It is captured per bank on the first row of a
//   block. A bank marked passthru is read back row by row, in write order,
//   instead of being transposed.
module transpose_pp #(
  parameter int W = 12,
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_valid,
  output logic           wr_ready,
  input  logic [N*W-1:0] wr_data,
`ifdef TRANSPOSE_PP_PASSTHRU_EN
  input  logic           passthru,
`endif
  output logic           rd_valid,
  input  logic           rd_ready,
  output logic [N*W-1:0] rd_data,
  output logic           rd_first,
  output logic           rd_last
);

  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] IDX_LAST = AW'(N - 1);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);

  // Storage is indexed as [bank][row][column] and is never reset.
  logic [W-1:0] mem_q [2][N][N];
`ifdef TRANSPOSE_PP_PASSTHRU_EN
  logic [1:0]   pt_q;
`endif

  logic [1:0]    full_q,    full_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] wr_row_q,  wr_row_d;
  logic [AW-1:0] rd_col_q,  rd_col_d;

  logic wr_acc;
  logic rd_acc;

  assign wr_ready = ~full_q[wr_bank_q];
  assign rd_valid = full_q[rd_bank_q];
  assign wr_acc   = wr_valid & wr_ready;
  assign rd_acc   = rd_valid & rd_ready;

  // The consumer qualifies these with rd_valid.
  assign rd_first = (rd_col_q == '0);
  assign rd_last  = (rd_col_q == IDX_LAST);

  // Next-state for both pointers and the bank-full flags. A simultaneous
  // write and read accept always touch different banks, so both updates
  // can be applied in the same cycle.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_row_d  = wr_row_q;
    rd_col_d  = rd_col_q;

    if (wr_acc) begin
      if (wr_row_q == IDX_LAST) begin
        wr_row_d          = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_row_d = wr_row_q + IDX_ONE;
      end
    end

    if (rd_acc) begin
      if (rd_col_q == IDX_LAST) begin
        rd_col_d          = '0;
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end else begin
        rd_col_d = rd_col_q + IDX_ONE;
      end
    end
  end

  // Control state register; reset discards every partial and full block.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_row_q  <= '0;
      rd_col_q  <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_row_q  <= wr_row_d;
      rd_col_q  <= rd_col_d;
    end
  end

  // Row write into the bank being filled; column 0 sits in the MSBs.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int c = 0; c < N; c++) begin
        mem_q[wr_bank_q][wr_row_q][AW'(c)] <= wr_data[(N-1-c)*W +: W];
      end
    end
  end

`ifdef TRANSPOSE_PP_PASSTHRU_EN
  // Per-bank passthru flag, captured with the first row of each block.
  always_ff @(posedge clk) begin
    if (wr_acc && (wr_row_q == '0)) begin
      pt_q[wr_bank_q] <= passthru;
    end
  end
`endif

  // Read mux: column rd_col of the read bank, row 0 in the LSBs. The bank
  // is never written while full, so the column holds under backpressure.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < N; k++) begin
`ifdef TRANSPOSE_PP_PASSTHRU_EN
      if (pt_q[rd_bank_q]) begin
        rd_data[k*W +: W] = mem_q[rd_bank_q][rd_col_q][AW'(k)];
      end else begin
        rd_data[k*W +: W] = mem_q[rd_bank_q][AW'(k)][rd_col_q];
      end
`else
      rd_data[k*W +: W] = mem_q[rd_bank_q][AW'(k)][rd_col_q];
`endif
    end
  end

  // A stalled column must not change, and the two sides never share a bank.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(wr_acc && rd_acc && (wr_bank_q == rd_bank_q)))
        else $error("transpose_pp: write and read accepted on the same bank");
    end
  end

  assert property (@(posedge clk) disable iff (rst)
                   (rd_valid && !rd_ready) |=> $stable(rd_data))
    else $error("transpose_pp: rd_data changed while stalled");

endmodule

// File: tb/tb_transpose_pp.sv
module tb_transpose_pp;

  localparam int W = 12;
  localparam int N = 8;

  logic           clk;
  logic           rst;
  logic           wr_valid;
  logic           wr_ready;
  logic [N*W-1:0] wr_data;
  logic           passthru;
  logic           rd_valid;
  logic           rd_ready;
  logic [N*W-1:0] rd_data;
  logic           rd_first;
  logic           rd_last;

  int n_checks = 0;
  int n_fail   = 0;

  transpose_pp #(.W(W), .N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
`ifdef TRANSPOSE_PP_PASSTHRU_EN
    .passthru (passthru),
`endif
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_first (rd_first),
    .rd_last  (rd_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: 256*b + 16*r + c; mode 1: scrambled so long runs stay distinct.
  function automatic logic [W-1:0] elem(input int mode, input int b, input int r, input int c);
    int v;
    if (mode == 0) v = 256*b + 16*r + c;
    else           v = 173*b + 16*r + c;
    return v[W-1:0];
  endfunction

  function automatic logic [N*W-1:0] row_vec(input int mode, input int b, input int r);
    logic [N*W-1:0] v;
    v = '0;
    for (int c = 0; c < N; c++) v[(N-1-c)*W +: W] = elem(mode, b, r, c);
    return v;
  endfunction

  function automatic logic [N*W-1:0] col_exp(input int mode, input int b, input int c, input bit pt);
    logic [N*W-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) begin
      if (pt) v[k*W +: W] = elem(mode, b, c, k);
      else    v[k*W +: W] = elem(mode, b, k, c);
    end
    return v;
  endfunction

  // Streams nblk blocks through an empty DUT with a block-count model.
  // pt0 marks block 0 as passthru (only meaningful with the feature).
  task automatic run_stream(input string tag, input int nblk, input int mode,
                            input int wpct, input int rpct, input bit pt0);
    int  wb = 0, wrow = 0, rb = 0, rc = 0, cyc = 0;
    bit  wv, rr, exp_wrdy, exp_rval, pt;
    while (rb < nblk && cyc < 40000) begin
      exp_wrdy = ((wb - rb) < 2);
      exp_rval = (wb > rb);
      check({tag, "_wr_ready"}, wr_ready, exp_wrdy);
      check({tag, "_rd_valid"}, rd_valid, exp_rval);
      if (exp_rval) begin
        pt = pt0 && (rb == 0);
        check({tag, "_rd_data"},  rd_data,  col_exp(mode, rb, rc, pt));
        check({tag, "_rd_first"}, rd_first, rc == 0);
        check({tag, "_rd_last"},  rd_last,  rc == N-1);
      end
      wv = (wb < nblk) && ($urandom_range(99) < wpct);
      rr = ($urandom_range(99) < rpct);
      wr_valid = wv;
      rd_ready = rr;
      wr_data  = wv ? row_vec(mode, wb, wrow) : {N*W{1'b1}};
      passthru = pt0 && (wb == 0);
      tick();
      cyc++;
      if (wv && exp_wrdy) begin
        if (wrow == N-1) begin wrow = 0; wb++; end
        else wrow++;
      end
      if (rr && exp_rval) begin
        if (rc == N-1) begin rc = 0; rb++; end
        else rc++;
      end
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    passthru = 1'b0;
    check({tag, "_blocks_out"}, rb, nblk);
  endtask

  initial begin
    logic [N*W-1:0] held;
    rst = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0; passthru = 1'b0;
    tick(); tick();
    check("rst_wr_ready", wr_ready, 1'b1);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_first", rd_first, 1'b1);
    check("rst_rd_last",  rd_last,  1'b0);
    rst = 1'b0;
    tick();

    // Single block, then four blocks back to back at full rate.
    run_stream("single", 1, 0, 100, 100, 1'b0);
    run_stream("b2b", 4, 0, 100, 100, 1'b0);

    // Backpressure: fill both banks with rd_ready low.
    for (int i = 0; i < 2*N; i++) begin
      check("bp_fill_wr_ready", wr_ready, 1'b1);
      wr_valid = 1'b1;
      wr_data  = row_vec(0, i / N, i % N);
      tick();
    end
    wr_data = {N*W{1'b1}};
    for (int k = 0; k < 5; k++) begin
      check("bp_full_wr_ready", wr_ready, 1'b0);
      check("bp_hold_rd_valid", rd_valid, 1'b1);
      check("bp_hold_rd_data",  rd_data,  col_exp(0, 0, 0, 1'b0));
      check("bp_hold_rd_first", rd_first, 1'b1);
      tick();
    end
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    for (int c = 0; c < N; c++) begin
      check("bp_drain0_wr_ready", wr_ready, 1'b0);
      check("bp_drain0_rd_data",  rd_data,  col_exp(0, 0, c, 1'b0));
      tick();
    end
    check("bp_release_wr_ready", wr_ready, 1'b1);
    for (int c = 0; c < N; c++) begin
      check("bp_drain1_rd_data", rd_data, col_exp(0, 1, c, 1'b0));
      check("bp_drain1_rd_last", rd_last, c == N-1);
      tick();
    end
    rd_ready = 1'b0;
    check("bp_empty_rd_valid", rd_valid, 1'b0);

    // Random handshakes on both sides.
    run_stream("rand", 200, 1, 50, 50, 1'b0);

    // Reset with block 1 partly written and block 0 half read.
    for (int i = 0; i < N + 5; i++) begin
      wr_valid = 1'b1;
      wr_data  = row_vec(0, i / N, i % N);
      tick();
    end
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    for (int c = 0; c < N/2; c++) begin
      check("mid_rd_data", rd_data, col_exp(0, 0, c, 1'b0));
      tick();
    end
    rd_ready = 1'b0;
    held = rd_data;
    check("mid_pre_rst_rd_data", held, col_exp(0, 0, N/2, 1'b0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_rd_valid", rd_valid, 1'b0);
    check("mid_rst_wr_ready", wr_ready, 1'b1);
    check("mid_rst_rd_first", rd_first, 1'b1);
    tick();
    run_stream("post_rst", 1, 1, 100, 100, 1'b0);

`ifdef TRANSPOSE_PP_PASSTHRU_EN
    run_stream("passthru", 2, 0, 100, 100, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/transpose_pp.md
Name: transpose_pp

Overview:
- Parametrised double-buffered (ping-pong) transpose memory between the row and column DCT passes of the JPEG accelerator.
- Accepts one N-element row per beat and returns the N x N block column by column.
- Two banks let block k+1 be written while block k is read, so each side sustains one beat per cycle.
- Valid/ready handshakes on both sides replace the bare wr/rd strobes of the previous generation.

Parameters:
- W, 12, bits per element.
- N, 8, elements per row and rows per block; N >= 2, power of two.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_valid  input  1  wr_data holds a valid row.
- wr_ready  output  1  block can accept a row this cycle.
- wr_data  input  N*W  row; column c element at bits [(N-1-c)*W +: W] (column 0 in MSBs).
- rd_valid  output  1  rd_data holds a valid column.
- rd_ready  input  1  consumer takes the column this cycle.
- rd_data  output  N*W  column; row r element at bits [r*W +: W] (row 0 in LSBs).
- rd_first  output  1  rd_data is column 0 of a block.
- rd_last  output  1  rd_data is column N-1 of a block.

Behaviour:
- Storage: two banks, each N x N x W registers. No reset on storage.
- State: full[1:0], wr_bank, rd_bank, wr_row and rd_col (both $clog2(N) bits).
- Reset values: full=0, wr_bank=0, rd_bank=0, wr_row=0, rd_col=0.
- Reset outputs: wr_ready=1, rd_valid=0, rd_first=1, rd_last=0.
- wr_ready = !full[wr_bank]. A write is accepted when wr_valid && wr_ready.
- On write accept: row wr_row of bank wr_bank <= wr_data; wr_row increments.
  - If wr_row==N-1: wr_row<=0, full[wr_bank]<=1, wr_bank toggles.
- rd_valid = full[rd_bank]. A read is accepted when rd_valid && rd_ready.
- rd_data is combinational from bank rd_bank: element r = row r, column rd_col.
  - rd_data must be held stable while rd_valid && !rd_ready.
- On read accept: rd_col increments.
  - If rd_col==N-1: rd_col<=0, full[rd_bank]<=0, rd_bank toggles.
- rd_first = (rd_col==0). rd_last = (rd_col==N-1). Both qualified only by rd_valid.
- Latency: rd_valid rises the cycle after the Nth row of a block is accepted.
- Throughput: with both sides always ready, N beats per block per side, no bubbles; read of block k overlaps write of block k+1.
- Both banks full: wr_ready=0 until the Nth column of rd_bank is accepted. wr_ready rises the cycle after that accept.
- Both banks empty: rd_valid=0. wr_valid toggling mid-block only stalls wr_row; no partial block is ever exposed.
- Simultaneous write and read accept always target different banks, since one bank must be full and the other not. Both updates happen in the same cycle.
- Simultaneous final-row write and final-column read: both full bits and both pointers update in the same cycle, with no conflict.
- rst mid-block: all partial and full blocks are discarded. Pointers and counters return to reset values on the next edge; stale storage contents are never presented because rd_valid=0.
- wr_data is ignored when not accepted. rd_ready is ignored when rd_valid=0.

Optional Feature:
- Macro: TRANSPOSE_PP_PASSTHRU_EN.
- Defined: adds input port passthru (1 bit), sampled and stored per bank on that block's first row write.
  - For a bank marked passthru, the read side returns the stored rows in write order instead of columns. rd_data = row rd_col, with element c at bits [c*W +: W].
  - Handshake, rd_first/rd_last and timing are unchanged.
- Undefined: no passthru port; every block is transposed.

Test Plan:
- Reset then N=8, W=12: write 8 rows, element(r,c)=16*r+c, rd_ready=1 -> rd_valid rises 1 cycle after the 8th accept. Column c reads element r = 16*r+c. rd_first on column 0, rd_last on column 7.
- Back-to-back: 4 blocks streamed with wr_valid=rd_ready=1 (block b element = 256*b+16*r+c) -> wr_ready never drops. 32 columns out, correct per block, no gaps after the first rd_valid.
- Backpressure: rd_ready=0, write 16 rows -> wr_ready=0 after the 16th accept. Hold 5 cycles: rd_data constant, column 0 of block 0. Then release rd_ready -> after 8 reads, wr_ready=1 the next cycle.
- Random wr_valid/rd_ready (50% each, 200 blocks) -> output equals the reference transpose. No data loss or duplication; full never both 0 while rd_valid=1.
- rst asserted after 5 rows of block 1 while block 0 is half read -> next cycle rd_valid=0, wr_ready=1. A fresh block written afterwards reads back correctly from column 0.
- With TRANSPOSE_PP_PASSTHRU_EN: block 0 passthru=1, block 1 passthru=0 -> block 0 out as rows 0..7 (element c = 16*r+c at bits [c*12 +: 12]). Block 1 out transposed.
